// File: rtl/riscv_core_mul_ctrl.sv
// RV64M multiply sequencer: sign handling and handshakes around an unsigned shift-add core.
// Optional RV_MUL_ZERO_BYPASS_EN: a zero effective operand skips the core and completes immediately.
module riscv_core_mul_ctrl (
  input  logic           i_booth_clk,
  input  logic           i_booth_rstn,
  input  logic           i_mul_valid,
  output logic           o_mul_ready,
  input  logic [2:0]     i_mul_funct3,
  input  logic           i_mul_is_word,
  input  logic [63:0]    i_mul_rs1,
  input  logic [63:0]    i_mul_rs2,
  input  logic           i_mul_kill,
  output logic           o_mul_valid,
  input  logic           i_mul_ack,
  output logic [63:0]    o_mul_result,
  output logic           o_booth_en,
  output logic [63:0]    o_booth_multiplicand,
  output logic [63:0]    o_booth_multiplier,
  input  logic           i_booth_done,
  input  logic [127:0]   i_booth_product
);

  localparam int unsigned XLEN = 64;
  localparam int unsigned PW   = 2 * XLEN;
  localparam int unsigned HW   = XLEN / 2;

  localparam logic [1:0] SEL_LO = 2'd0;
  localparam logic [1:0] SEL_HI = 2'd1;
  localparam logic [1:0] SEL_W  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_FIXUP = 3'd3,
    ST_DONE  = 3'd4,
    ST_DRAIN = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic              ready_q, ready_d;
  logic              valid_q, valid_d;
  logic              en_q, en_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic              neg_q, neg_d;
  logic [1:0]        sel_q, sel_d;
  logic [PW-1:0]     prod_q, prod_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic [XLEN-1:0]   req_rs1, req_rs2;
  logic              req_s1, req_s2;
  logic [1:0]        req_sel;
  logic [PW-1:0]     fixed;
`ifdef RV_MUL_ZERO_BYPASS_EN
  logic              req_zero;
`endif

  // Request decode: effective operands, signedness and result select
  always_comb begin : req_decode
    req_rs1 = i_mul_is_word ? {HW'(0), i_mul_rs1[HW-1:0]} : i_mul_rs1;
    req_rs2 = i_mul_is_word ? {HW'(0), i_mul_rs2[HW-1:0]} : i_mul_rs2;
    req_s1  = !i_mul_is_word && ((i_mul_funct3 == 3'b001) || (i_mul_funct3 == 3'b010))
              && i_mul_rs1[XLEN-1];
    req_s2  = !i_mul_is_word && (i_mul_funct3 == 3'b001) && i_mul_rs2[XLEN-1];
    if (i_mul_is_word)              req_sel = SEL_W;
    else if (i_mul_funct3 == 3'b000) req_sel = SEL_LO;
    else                            req_sel = SEL_HI;
`ifdef RV_MUL_ZERO_BYPASS_EN
    req_zero = (req_rs1 == '0) || (req_rs2 == '0);
`endif
  end

  always_ff @(posedge i_booth_clk or negedge i_booth_rstn) begin : regs
    if (!i_booth_rstn) begin
      state_q  <= ST_IDLE;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      en_q     <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      sel_q    <= SEL_LO;
      prod_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      en_q     <= en_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      sel_q    <= sel_d;
      prod_q   <= prod_d;
      result_q <= result_d;
    end
  end

  // Next state; a kill coinciding with done in WAIT needs no drain
  always_comb begin : next_state
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!i_mul_kill && i_mul_valid) begin
`ifdef RV_MUL_ZERO_BYPASS_EN
          state_d = req_zero ? ST_DONE : ST_ISSUE;
`else
          state_d = ST_ISSUE;
`endif
        end
      end
      ST_ISSUE: state_d = i_mul_kill ? ST_DRAIN : ST_WAIT;
      ST_WAIT: begin
        if (i_mul_kill)        state_d = i_booth_done ? ST_IDLE : ST_DRAIN;
        else if (i_booth_done) state_d = ST_FIXUP;
      end
      ST_FIXUP: state_d = i_mul_kill ? ST_IDLE : ST_DONE;
      ST_DONE:  if (i_mul_kill || i_mul_ack) state_d = ST_IDLE;
      ST_DRAIN: if (i_booth_done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Registered outputs follow the next state; datapath loads on transitions
  always_comb begin : outputs
    ready_d  = (state_d == ST_IDLE);
    valid_d  = (state_d == ST_DONE);
    en_d     = (state_d == ST_ISSUE);
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    sel_d    = sel_q;
    prod_d   = prod_q;
    result_d = result_q;
    fixed    = neg_q ? -prod_q : prod_q;

    if ((state_q == ST_IDLE) && (state_d != ST_IDLE)) begin
      mcand_d  = req_s1 ? -req_rs1 : req_rs1;
      mplier_d = req_s2 ? -req_rs2 : req_rs2;
      neg_d    = req_s1 ^ req_s2;
      sel_d    = req_sel;
      result_d = '0;
    end

    if ((state_q == ST_WAIT) && (state_d == ST_FIXUP)) prod_d = i_booth_product;

    if ((state_q == ST_FIXUP) && (state_d == ST_DONE)) begin
      unique case (sel_q)
        SEL_LO:  result_d = fixed[XLEN-1:0];
        SEL_W:   result_d = {{HW{fixed[HW-1]}}, fixed[HW-1:0]};
        default: result_d = fixed[PW-1:XLEN];
      endcase
    end
  end

  assign o_mul_ready          = ready_q;
  assign o_mul_valid          = valid_q;
  assign o_mul_result         = result_q;
  assign o_booth_en           = en_q;
  assign o_booth_multiplicand = mcand_q;
  assign o_booth_multiplier   = mplier_q;

endmodule

// File: tb/tb_riscv_core_mul_ctrl.sv
// Bench for riscv_core_mul_ctrl: 64-cycle core model, directed table, corner sequences, random ops.
module tb_riscv_core_mul_ctrl;

`ifdef RV_MUL_ZERO_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         i_mul_valid = 1'b0;
  logic         o_mul_ready;
  logic [2:0]   i_mul_funct3 = 3'd0;
  logic         i_mul_is_word = 1'b0;
  logic [63:0]  i_mul_rs1 = '0;
  logic [63:0]  i_mul_rs2 = '0;
  logic         i_mul_kill = 1'b0;
  logic         o_mul_valid;
  logic         i_mul_ack = 1'b0;
  logic [63:0]  o_mul_result;
  logic         o_booth_en;
  logic [63:0]  o_booth_multiplicand;
  logic [63:0]  o_booth_multiplier;
  logic         core_done = 1'b0;
  logic [127:0] core_prod = '0;

  int n_cmp = 0;
  int n_err = 0;

  riscv_core_mul_ctrl dut (
    .i_booth_clk          (clk),
    .i_booth_rstn         (rstn),
    .i_mul_valid          (i_mul_valid),
    .o_mul_ready          (o_mul_ready),
    .i_mul_funct3         (i_mul_funct3),
    .i_mul_is_word        (i_mul_is_word),
    .i_mul_rs1            (i_mul_rs1),
    .i_mul_rs2            (i_mul_rs2),
    .i_mul_kill           (i_mul_kill),
    .o_mul_valid          (o_mul_valid),
    .i_mul_ack            (i_mul_ack),
    .o_mul_result         (o_mul_result),
    .o_booth_en           (o_booth_en),
    .o_booth_multiplicand (o_booth_multiplicand),
    .o_booth_multiplier   (o_booth_multiplier),
    .i_booth_done         (core_done),
    .i_booth_product      (core_prod)
  );

  always #5 clk = ~clk;

  // Multiplier core: launch seen in cycle T+1, done pulse in cycle T+65
  int          core_cnt = 0;
  int          en_count = 0;
  int          n_overlap = 0;
  logic [63:0] core_a = '0, core_b = '0;
  always @(negedge clk) begin
    core_done = 1'b0;
    if (core_cnt > 0) begin
      core_cnt = core_cnt - 1;
      if (core_cnt == 0) begin
        core_done = 1'b1;
        core_prod = {64'd0, core_a} * {64'd0, core_b};
      end
    end
    if (o_booth_en === 1'b1) begin
      if (core_cnt > 0) n_overlap = n_overlap + 1;
      en_count = en_count + 1;
      core_cnt = 64;
      core_a   = o_booth_multiplicand;
      core_b   = o_booth_multiplier;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: RISC-V M semantics via 128-bit two's-complement arithmetic
  function automatic logic [63:0] ref_mul(input logic [2:0] f3, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
    logic [127:0] sa, sb, p;
    if (w) begin
      p = {96'd0, a[31:0]} * {96'd0, b[31:0]};
      return {{32{p[31]}}, p[31:0]};
    end
    sa = {64'd0, a};
    sb = {64'd0, b};
    if (f3 == 3'd1 || f3 == 3'd2) sa = {{64{a[63]}}, a};
    if (f3 == 3'd1)               sb = {{64{b[63]}}, b};
    p = sa * sb;
    return (f3 == 3'd0) ? p[63:0] : p[127:64];
  endfunction

  function automatic logic [63:0] ref_mag(input logic [63:0] x, input logic w, input logic sgn);
    logic [63:0] e;
    e = w ? {32'd0, x[31:0]} : x;
    if (!w && sgn && e[63]) e = -e;
    return e;
  endfunction

  task automatic issue(input logic [2:0] f3, input logic w, input logic [63:0] a, input logic [63:0] b);
    int k = 0;
    while (o_mul_ready !== 1'b1 && k < 300) begin tick(); k++; end
    check("issue_ready", o_mul_ready, 1'b1);
    i_mul_funct3  = f3;
    i_mul_is_word = w;
    i_mul_rs1     = a;
    i_mul_rs2     = b;
    i_mul_valid   = 1'b1;
    tick();
    i_mul_valid   = 1'b0;
  endtask

  task automatic run_op(input string nm, input logic [2:0] f3, input logic w,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input int ack_dly);
    int en0, k, exp_lat, exp_en;
    bit zero;
    zero    = w ? (a[31:0] == 0 || b[31:0] == 0) : (a == 0 || b == 0);
    exp_lat = (BYPASS && zero) ? 1 : 67;
    exp_en  = (BYPASS && zero) ? 0 : 1;
    en0 = en_count;
    issue(f3, w, a, b);
    k = 1;
    if (exp_en == 1) begin
      check({nm, "_mcand"}, o_booth_multiplicand, ref_mag(a, w, f3 == 3'd1 || f3 == 3'd2));
      check({nm, "_mplier"}, o_booth_multiplier, ref_mag(b, w, f3 == 3'd1));
    end
    while (o_mul_valid !== 1'b1 && k < 200) begin tick(); k++; end
    check({nm, "_lat"}, 128'(k), 128'(exp_lat));
    check({nm, "_en"}, 128'(en_count - en0), 128'(exp_en));
    check({nm, "_res"}, o_mul_result, exp);
    repeat (ack_dly) tick();
    if (ack_dly > 0) check({nm, "_hold"}, {o_mul_valid, o_mul_result}, {1'b1, exp});
    i_mul_ack = 1'b1;
    tick();
    i_mul_ack = 1'b0;
    check({nm, "_drop"}, {o_mul_valid, o_mul_ready}, 2'b01);
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[11];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int k, en0;
    bit bad;
    logic [2:0]  rf3;
    logic        rw;
    logic [63:0] ra, rb;

    vecs[0]  = '{3'd0, 1'b0, 64'd7, 64'd6, 64'h2A};
    vecs[1]  = '{3'd1, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000};
    vecs[2]  = '{3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
    vecs[3]  = '{3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[4]  = '{3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 64'h2};
    vecs[5]  = '{3'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA};
    vecs[6]  = '{3'd0, 1'b1, 64'h1_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE};
    vecs[7]  = '{3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[8]  = '{3'd7, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000};
    vecs[9]  = '{3'd1, 1'b1, 64'hFFFF_FFFF_0000_0003, 64'd5, 64'd15};
    vecs[10] = '{3'd1, 1'b0, 64'h1234, 64'd0, 64'd0};

    // Reset values, both during and just after reset
    repeat (3) tick();
    check("rst_ready", o_mul_ready, 1'b1);
    check("rst_valid", o_mul_valid, 1'b0);
    check("rst_result", o_mul_result, 64'd0);
    check("rst_en", o_booth_en, 1'b0);
    check("rst_ops", {o_booth_multiplicand, o_booth_multiplier}, 128'd0);
    rstn = 1'b1;
    tick();
    check("post_rst", {o_mul_ready, o_mul_valid, o_booth_en}, 3'b100);

    for (int i = 0; i < 11; i++)
      run_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].w, vecs[i].a, vecs[i].b, vecs[i].exp, i % 3);

    // Kill in IDLE beats a simultaneous request
    en0 = en_count;
    i_mul_rs1 = 64'd5; i_mul_rs2 = 64'd5; i_mul_funct3 = 3'd0; i_mul_is_word = 1'b0;
    i_mul_valid = 1'b1; i_mul_kill = 1'b1;
    tick();
    i_mul_valid = 1'b0; i_mul_kill = 1'b0;
    check("kill_idle_ready", o_mul_ready, 1'b1);
    tick(); tick();
    check("kill_idle_quiet", {28'(en_count - en0), o_mul_valid}, 29'd0);

    // Kill during WAIT: drain until the core's done, then accept again
    en0 = en_count;
    issue(3'd0, 1'b0, 64'd7, 64'd9);
    k = 1; bad = 1'b0;
    while (k < 65) begin
      if (k == 20) i_mul_kill = 1'b1;
      tick();
      i_mul_kill = 1'b0;
      k++;
      if (o_mul_valid !== 1'b0) bad = 1'b1;
    end
    check("kill_wait_novalid", bad, 1'b0);
    check("kill_wait_en", 128'(en_count - en0), 128'd1);
    check("kill_wait_busy", o_mul_ready, 1'b0);
    tick();
    check("kill_wait_ready", o_mul_ready, 1'b1);
    run_op("after_kill", 3'd0, 1'b0, 64'd3, 64'd5, 64'd15, 0);

    // Kill while the result is presented
    issue(3'd0, 1'b0, 64'd11, 64'd13);
    k = 1;
    while (o_mul_valid !== 1'b1 && k < 200) begin tick(); k++; end
    check("kill_done_res", {o_mul_valid, o_mul_result}, {1'b1, 64'd143});
    i_mul_kill = 1'b1;
    tick();
    i_mul_kill = 1'b0;
    check("kill_done_drop", {o_mul_valid, o_mul_ready}, 2'b01);

    // Reset mid-WAIT; the later done pulse is stale and must be ignored
    en0 = en_count;
    issue(3'd0, 1'b0, 64'd7, 64'd6);
    k = 1;
    while (k < 30) begin tick(); k++; end
    rstn = 1'b0;
    #1;
    check("midrst_ready", o_mul_ready, 1'b1);
    check("midrst_valid_res", {o_mul_valid, o_mul_result}, 65'd0);
    check("midrst_booth", {o_booth_en, o_booth_multiplicand, o_booth_multiplier}, 129'd0);
    tick(); tick();
    rstn = 1'b1;
    k += 2; bad = 1'b0;
    while (k < 75) begin
      tick(); k++;
      if (o_mul_valid !== 1'b0 || o_booth_en !== 1'b0 || o_mul_ready !== 1'b1) bad = 1'b1;
    end
    check("midrst_stale", bad, 1'b0);
    check("midrst_en", 128'(en_count - en0), 128'd1);
    run_op("after_rst", 3'd0, 1'b0, 64'd7, 64'd6, 64'h2A, 1);

    // Random operations against the reference model
    for (int i = 0; i < 40; i++) begin
      rf3 = 3'($urandom_range(0, 7));
      rw  = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 5))
        0:       ra = 64'd0;
        1:       ra = 64'h8000_0000_0000_0000;
        2:       ra = 64'hFFFF_FFFF_FFFF_FFFF;
        default: ra = {$urandom, $urandom};
      endcase
      case ($urandom_range(0, 5))
        0:       rb = 64'd0;
        1:       rb = 64'h8000_0000_0000_0000;
        2:       rb = 64'hFFFF_FFFF_FFFF_FFFF;
        default: rb = {$urandom, $urandom};
      endcase
      run_op($sformatf("rnd%0d", i), rf3, rw, ra, rb, ref_mul(rf3, rw, ra, rb),
             int'($urandom_range(0, 3)));
    end

    check("core_overlap", 128'(n_overlap), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
